// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - funct codes and PC step shared by the MIPS execute-stage ALU
package mips_pkg;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_NOR  = 5'd5,
      ALU_SLT  = 5'd6,
      ALU_SLTU = 5'd7,
      ALU_SLL  = 5'd8,
      ALU_SRL  = 5'd9,
      ALU_SRA  = 5'd10,
      ALU_SLLV = 5'd11,
      ALU_SRLV = 5'd12,
      ALU_SRAV = 5'd13,
      ALU_LUI  = 5'd14,
      ALU_BEQ  = 5'd15,
      ALU_BNE  = 5'd16
   } alu_funct_e;

   localparam int unsigned PC_INC = 4;

   function automatic logic funct_valid(input logic [4:0] funct);
      return funct <= ALU_BNE;
   endfunction

   // Logical ops treat the immediate as unsigned; everything else sign-extends it.
   function automatic logic imm_zero_ext(input logic [4:0] funct);
      return (funct == ALU_AND) || (funct == ALU_OR) || (funct == ALU_XOR);
   endfunction

endpackage

// File: rtl/mips_alu_comb.sv
// rtl/mips_alu_comb.sv - combinational result, branch decision and next-PC for the ALU
module mips_alu_comb
   import mips_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int IMM_WIDTH = 16,
   parameter int PC_WIDTH  = 32
) (
   input  logic [DWIDTH-1:0]    data_rs,
   input  logic [DWIDTH-1:0]    data_rt,
   input  logic [IMM_WIDTH-1:0] imm,
   input  logic [4:0]           funct,
   input  logic                 alu_src,
   input  logic [PC_WIDTH-1:0]  pc,
   output logic [DWIDTH-1:0]    result,
   output logic                 taken,
   output logic [PC_WIDTH-1:0]  next_pc,
   output logic                 valid
);

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INC);

   logic [DWIDTH-1:0]   imm_sext;
   logic [DWIDTH-1:0]   imm_zext;
   logic [DWIDTH-1:0]   op_b;
   logic [4:0]          shamt;
   logic [4:0]          shvar;
   logic [PC_WIDTH-1:0] pc_seq;
   logic [PC_WIDTH-1:0] br_off;
   logic                rs_eq_rt;

   assign imm_sext = {{(DWIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   assign imm_zext = {{(DWIDTH-IMM_WIDTH){1'b0}}, imm};
   assign op_b     = !alu_src          ? data_rt  :
                     imm_zero_ext(funct) ? imm_zext : imm_sext;
   assign shamt    = imm[10:6];
   assign shvar    = data_rs[4:0];
   assign rs_eq_rt = (data_rs == data_rt);

   assign pc_seq = pc + PC_STEP;
   assign br_off = {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} << 2;

   always_comb begin
      result = '0;
      taken  = 1'b0;
      case (funct)
         ALU_ADD:  result = data_rs + op_b;
         ALU_SUB:  result = data_rs - op_b;
         ALU_AND:  result = data_rs & op_b;
         ALU_OR:   result = data_rs | op_b;
         ALU_XOR:  result = data_rs ^ op_b;
         ALU_NOR:  result = ~(data_rs | data_rt);
         ALU_SLT:  result = {{(DWIDTH-1){1'b0}}, ($signed(data_rs) < $signed(op_b))};
         ALU_SLTU: result = {{(DWIDTH-1){1'b0}}, (data_rs < op_b)};
         ALU_SLL:  result = data_rt << shamt;
         ALU_SRL:  result = data_rt >> shamt;
         ALU_SRA:  result = $signed(data_rt) >>> shamt;
         ALU_SLLV: result = data_rt << shvar;
         ALU_SRLV: result = data_rt >> shvar;
         ALU_SRAV: result = $signed(data_rt) >>> shvar;
         ALU_LUI:  result = {imm, {(DWIDTH-IMM_WIDTH){1'b0}}};
         ALU_BEQ:  taken  = rs_eq_rt;
         ALU_BNE:  taken  = !rs_eq_rt;
         default:  result = '0;
      endcase
   end

   assign next_pc = taken ? (pc_seq + br_off) : pc_seq;
   assign valid   = funct_valid(funct);

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - registered execute-stage ALU, one-cycle latency, async active-low reset
module mips_alu
   import mips_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int IMM_WIDTH = 16,
   parameter int PC_WIDTH  = 32
) (
   input  logic                 a_i_clk,
   input  logic                 a_i_rst,
   input  logic [DWIDTH-1:0]    a_i_data_rs,
   input  logic [DWIDTH-1:0]    a_i_data_rt,
   input  logic [IMM_WIDTH-1:0] a_i_imm,
   input  logic [4:0]           a_i_funct,
   input  logic                 a_i_alu_src,
   input  logic [PC_WIDTH-1:0]  a_i_pc,
   output logic [DWIDTH-1:0]    alu_value,
   output logic [PC_WIDTH-1:0]  alu_pc,
   output logic                 done
);

   logic [DWIDTH-1:0]   comb_result;
   logic                comb_taken;
   logic [PC_WIDTH-1:0] comb_next_pc;
   logic                comb_valid;

   mips_alu_comb #(
      .DWIDTH    (DWIDTH),
      .IMM_WIDTH (IMM_WIDTH),
      .PC_WIDTH  (PC_WIDTH)
   ) u_comb (
      .data_rs (a_i_data_rs),
      .data_rt (a_i_data_rt),
      .imm     (a_i_imm),
      .funct   (a_i_funct),
      .alu_src (a_i_alu_src),
      .pc      (a_i_pc),
      .result  (comb_result),
      .taken   (comb_taken),
      .next_pc (comb_next_pc),
      .valid   (comb_valid)
   );

   // The taken flag is already folded into next_pc; it stays visible for debug only.
   logic unused_taken;
   assign unused_taken = comb_taken;

   always_ff @(posedge a_i_clk or negedge a_i_rst) begin
      if (!a_i_rst) begin
         alu_value <= '0;
         alu_pc    <= '0;
         done      <= 1'b0;
      end else begin
         alu_value <= comb_result;
         alu_pc    <= comb_next_pc;
         done      <= comb_valid;
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - randomized self-checking bench for mips_alu against a behavioural model
module tb_mips_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [15:0] imm;
   logic [4:0]  funct;
   logic        alu_src;
   logic [31:0] pc;
   logic [31:0] alu_value;
   logic [31:0] alu_pc;
   logic        done;

   int n_vec;
   int n_miss;

   mips_alu dut (
      .a_i_clk     (clk),
      .a_i_rst     (rst_n),
      .a_i_data_rs (rs),
      .a_i_data_rt (rt),
      .a_i_imm     (imm),
      .a_i_funct   (funct),
      .a_i_alu_src (alu_src),
      .a_i_pc      (pc),
      .alu_value   (alu_value),
      .alu_pc      (alu_pc),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h (rs=%h rt=%h imm=%h funct=%0d src=%0b pc=%h)",
                  tag, got, exp, rs, rt, imm, funct, alu_src, pc);
      end
   endtask

   function automatic int unsigned sra32(input int unsigned x, input int unsigned sh);
      int unsigned r;
      r = x >> sh;
      if (x[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
      return r;
   endfunction

   task automatic model(output logic [31:0] e_val, output logic [31:0] e_pc, output logic e_done);
      int unsigned a, b, t, sx, zx, sh, sv;
      a  = rs;
      t  = rt;
      sx = {{16{imm[15]}}, imm};
      zx = {16'h0, imm};
      if (!alu_src)                   b = t;
      else if (funct >= 2 && funct <= 4) b = zx;
      else                            b = sx;
      sh = imm[10:6];
      sv = a % 32;
      e_pc   = pc + 4;
      e_done = (funct <= 16);
      e_val  = 0;
      case (funct)
         0:  e_val = a + b;
         1:  e_val = a - b;
         2:  e_val = a & b;
         3:  e_val = a | b;
         4:  e_val = a ^ b;
         5:  e_val = ~(a | t);
         6:  e_val = (int'(a) < int'(b)) ? 1 : 0;
         7:  e_val = (a < b) ? 1 : 0;
         8:  e_val = t << sh;
         9:  e_val = t >> sh;
         10: e_val = sra32(t, sh);
         11: e_val = t << sv;
         12: e_val = t >> sv;
         13: e_val = sra32(t, sv);
         14: e_val = zx * 65536;
         15: if (a == t) e_pc = pc + 4 + sx * 4;
         16: if (a != t) e_pc = pc + 4 + sx * 4;
         default: e_val = 0;
      endcase
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [15:0] i,
                        input logic [4:0] f, input logic s, input logic [31:0] p, input string tag);
      logic [31:0] e_val, e_pc;
      logic        e_done;
      @(negedge clk);
      rs = a; rt = b; imm = i; funct = f; alu_src = s; pc = p;
      model(e_val, e_pc, e_done);
      @(posedge clk);
      #1;
      check({tag, ".value"}, alu_value, e_val);
      check({tag, ".pc"}, alu_pc, e_pc);
      check({tag, ".done"}, {31'h0, done}, {31'h0, e_done});
   endtask

   task automatic expect_zero(input string tag);
      check({tag, ".value"}, alu_value, 32'h0);
      check({tag, ".pc"}, alu_pc, 32'h0);
      check({tag, ".done"}, {31'h0, done}, 32'h0);
   endtask

   initial begin
      logic [31:0] ra, rb, rp;
      logic [15:0] ri;
      logic [4:0]  rf;
      n_vec = 0;
      n_miss = 0;
      rst_n = 1'b0;
      rs = 32'd5; rt = 32'd4; imm = 16'h0; funct = 5'd0; alu_src = 1'b0; pc = 32'd10;
      @(posedge clk);
      #1;
      expect_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      apply(32'd5, 32'd4, 16'h0, 5'd0, 1'b0, 32'd10, "add_rt");
      check("add_rt.lit", alu_value, 32'd9);
      apply(32'd5, 32'd0, 16'd10, 5'd0, 1'b1, 32'd10, "add_imm");
      check("add_imm.lit", alu_value, 32'd15);
      apply(32'd5, 32'd5, 16'd4, 5'd15, 1'b0, 32'd10, "beq_t");
      check("beq_t.lit", alu_pc, 32'd30);
      apply(32'd5, 32'd4, 16'd4, 5'd15, 1'b0, 32'd10, "beq_nt");
      check("beq_nt.lit", alu_pc, 32'd14);
      apply(32'd5, 32'd4, 16'hFFFE, 5'd16, 1'b0, 32'd100, "bne_back");
      apply(32'hFFFF_FFFF, 32'd1, 16'h0, 5'd6, 1'b0, 32'd0, "slt");
      check("slt.lit", alu_value, 32'd1);
      apply(32'hFFFF_FFFF, 32'd1, 16'h0, 5'd7, 1'b0, 32'd0, "sltu");
      check("sltu.lit", alu_value, 32'd0);
      apply(32'h0, 32'h8000_0000, 16'd4 << 6, 5'd10, 1'b0, 32'd0, "sra");
      check("sra.lit", alu_value, 32'hF800_0000);
      apply(32'h1234, 32'h8000_0000, 16'hFFFF, 5'd20, 1'b0, 32'd40, "illegal");
      apply(32'h0, 32'h0, 16'hABCD, 5'd14, 1'b0, 32'hFFFF_FFFC, "lui_wrap");
      apply(32'hF0F0_0000, 32'h0, 16'h8001, 5'd3, 1'b1, 32'd0, "or_zext");
      apply(32'h7FFF_FFFF, 32'd1, 16'h0, 5'd0, 1'b0, 32'd0, "add_wrap");

      // Asynchronous reset in the middle of a cycle, then resume.
      #2;
      rst_n = 1'b0;
      #1;
      expect_zero("rst_async");
      @(posedge clk);
      #1;
      expect_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      apply(32'd7, 32'd3, 16'h0, 5'd1, 1'b0, 32'd20, "post_rst");

      for (int k = 0; k < 1500; k++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         ri = 16'($urandom);
         rf = 5'($urandom_range(0, 31));
         rp = $urandom;
         apply(ra, rb, ri, rf, 1'($urandom), rp, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered integer ALU for the MIPS datapath execute stage.
- Takes register operands rs/rt, a 16-bit immediate, a 5-bit function code, an operand-select and the current PC.
- Produces the arithmetic/logic result, the next-PC value (sequential or branch target) and a done/valid flag.
- All outputs are registered with one-cycle latency.

Parameters:
- DWIDTH, 32, data width of operands and result
- IMM_WIDTH, 16, immediate field width
- PC_WIDTH, 32, program counter width

Ports:
- a_i_clk  input  1  clock, rising-edge
- a_i_rst  input  1  asynchronous reset, active-low
- a_i_data_rs  input  DWIDTH  operand A (rs register value)
- a_i_data_rt  input  DWIDTH  operand B candidate (rt register value)
- a_i_imm  input  IMM_WIDTH  instruction immediate
- a_i_funct  input  5  operation select
- a_i_alu_src  input  1  0 selects B = rt; 1 selects B = extended immediate
- a_i_pc  input  PC_WIDTH  PC of the current instruction
- alu_value  output  DWIDTH  registered result
- alu_pc  output  PC_WIDTH  registered next PC
- done  output  1  registered valid flag for the current funct

Behaviour:
- Reset (a_i_rst=0, asynchronous) forces alu_value=0, alu_pc=0 and done=0 immediately. These values hold while reset is low.
- After reset release, every rising edge captures a new result from the current inputs. Latency is exactly 1 cycle, there is no stall, and a new op may be issued every cycle.
- Operand B:
  - alu_src=0: B = rt.
  - alu_src=1, funct 0-1 and 6-7: B = sign-extended imm.
  - alu_src=1, funct 2-4: B = zero-extended imm.
- shamt = imm[10:6].
- Funct encoding (alu_value):
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR (uses rt)
  - 6 SLT signed, result 1/0
  - 7 SLTU unsigned, result 1/0
  - 8 SLL rt<<shamt
  - 9 SRL rt>>shamt logical
  - 10 SRA rt>>>shamt arithmetic
  - 11 SLLV rt<<rs[4:0]
  - 12 SRLV rt>>rs[4:0]
  - 13 SRAV rt>>>rs[4:0]
  - 14 LUI {imm,16'b0}
  - 15 BEQ
  - 16 BNE
- Arithmetic is modulo 2^DWIDTH. There is no overflow flag and no trap.
- Next PC:
  - Non-branch ops: alu_pc = a_i_pc + 4.
  - BEQ taken when rs==rt; BNE taken when rs!=rt.
  - Taken branch: alu_pc = a_i_pc + 4 + (sign-extended imm << 2).
  - Not-taken branch: alu_pc = a_i_pc + 4.
  - Branch ops write alu_value = 0.
  - PC arithmetic wraps modulo 2^PC_WIDTH.
- done:
  - Registered 1 on every clock edge after reset whose funct is 0-16.
  - Registered 0 for funct 17-31. For these codes alu_value = 0 and alu_pc = a_i_pc + 4.
- Reset asserted mid-operation discards the in-flight result. The first edge after release produces a fresh result from the inputs present at that edge.

Decomposition:
- Shared package (mips_pkg): funct code constants (ALU_ADD .. ALU_BNE) and the PC increment constant 4.
- One combinational sub-module is natural: mips_alu_comb, which computes the result, taken flag and next PC. The top level holds only the async-reset output registers.

Test Plan:
1. Reset low, then release; rs=5, rt=4, alu_src=0, funct=0, pc=10 -> after 1 edge: alu_value=9, alu_pc=14, done=1.
2. rs=5, imm=10, alu_src=1, funct=0, pc=10 -> alu_value=15, alu_pc=14, done=1.
3. rs=rt=5, imm=4, funct=15 (BEQ), pc=10 -> alu_value=0, alu_pc=30, done=1. Then rt=4 -> alu_pc=14.
4. Signed/unsigned compare: rs=0xFFFFFFFF, rt=1, funct=6 -> alu_value=1; funct=7 -> alu_value=0.
5. SRA: rt=0x80000000, imm shamt=4, funct=10 -> alu_value=0xF8000000. Then funct=20 (illegal) -> done=0, alu_value=0.
6. Assert a_i_rst low mid-stream, between clock edges -> outputs go to 0 immediately, without waiting for a clock edge. Release -> the next edge produces a valid result.
